// File: rtl/dqs_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dqs_pattern_pkg
// Description : State encoding and 4-bit DQS din/tin slice constants shared by
//               the per-lane DQS write/read pattern sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dqs_pattern_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_BURST = 3'd2,
        ST_POST  = 3'd3,
        ST_RD    = 3'd4
    } dqs_state_t;

    // Bit 0 of every slice is the earliest half-tCK on the wire.
    localparam logic [3:0] DQS_IDLE_D  = 4'b0000;
    localparam logic [3:0] DQS_IDLE_T  = 4'b1111;
    localparam logic [3:0] DQS_PRE_D   = 4'b0000;
    localparam logic [3:0] DQS_PRE_T   = 4'b0011;
    localparam logic [3:0] DQS_BURST_D = 4'b0101;
    localparam logic [3:0] DQS_BURST_T = 4'b0000;
    localparam logic [3:0] DQS_POST_D  = 4'b0000;
    localparam logic [3:0] DQS_POST_T  = 4'b1110;

endpackage
`default_nettype wire

// File: rtl/dqs_wr_pattern.sv
`default_nettype none
// ============================================================================
// Module      : dqs_wr_pattern
// Description : Per-byte-lane DQS sequencer: write preamble/burst/postamble
//               slices and read DCI termination window, one slice per clk_div.
//               Optional macro DQS_WR_SEAMLESS_EN chains back-to-back writes.
// Revision    : 1.0 - initial release
// ============================================================================
module dqs_wr_pattern
    import dqs_pattern_pkg::*;
#(
    parameter int LEN_WIDTH = 6,
    parameter int DCI_GUARD = 1
) (
    input  logic                 clk_div,
    input  logic                 rst_n,
    input  logic                 wr_start,
    input  logic [LEN_WIDTH-1:0] wr_bursts,
    input  logic                 rd_start,
    input  logic [LEN_WIDTH-1:0] rd_bursts,
    output logic                 busy,
    output logic                 wr_data_en,
    output logic                 last,
    output logic [3:0]           din,
    output logic [3:0]           tin,
    output logic                 dci_disable
);

    localparam int c_cnt_w = LEN_WIDTH + 2;
    localparam logic [c_cnt_w-1:0] c_guard2 = c_cnt_w'(2 * DCI_GUARD);

    dqs_state_t          r_state;
    dqs_state_t          w_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic [c_cnt_w-1:0]  w_wr_load;
    logic [c_cnt_w-1:0]  w_rd_load;

    logic [3:0]          w_din;
    logic [3:0]          w_tin;
    logic                w_dci_disable;
    logic                w_busy;
    logic                w_wr_data_en;
    logic                w_last;

    // Two slices per BL8: 2*(n+1)-1 is simply {n, 1}.
    assign w_wr_load = c_cnt_w'({wr_bursts, 1'b1});
    assign w_rd_load = c_cnt_w'({rd_bursts, 1'b1}) + c_guard2;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (wr_start) begin
                    w_next     = ST_PRE;
                    w_cnt_next = w_wr_load;
                end else if (rd_start) begin
                    w_next     = ST_RD;
                    w_cnt_next = w_rd_load;
                end
            end
            ST_PRE: begin
                w_next = ST_BURST;
            end
            ST_BURST: begin
                if (r_cnt == '0) begin
`ifdef DQS_WR_SEAMLESS_EN
                    if (wr_start) begin
                        w_next     = ST_BURST;
                        w_cnt_next = w_wr_load;
                    end else begin
                        w_next = ST_POST;
                    end
`else
                    w_next = ST_POST;
`endif
                end else begin
                    w_cnt_next = r_cnt - c_cnt_w'(1);
                end
            end
            ST_POST: begin
                w_next = ST_IDLE;
            end
            ST_RD: begin
                if (r_cnt == '0) begin
                    w_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - c_cnt_w'(1);
                end
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        w_din         = DQS_IDLE_D;
        w_tin         = DQS_IDLE_T;
        w_dci_disable = 1'b1;
        w_busy        = (w_next != ST_IDLE);
        w_wr_data_en  = 1'b0;
        w_last        = 1'b0;
        case (w_next)
            ST_PRE: begin
                w_din = DQS_PRE_D;
                w_tin = DQS_PRE_T;
            end
            ST_BURST: begin
                w_din        = DQS_BURST_D;
                w_tin        = DQS_BURST_T;
                w_wr_data_en = 1'b1;
                w_last       = (w_cnt_next == '0);
            end
            ST_POST: begin
                w_din = DQS_POST_D;
                w_tin = DQS_POST_T;
            end
            ST_RD: begin
                w_dci_disable = 1'b0;
            end
            default: begin
                w_din = DQS_IDLE_D;
                w_tin = DQS_IDLE_T;
            end
        endcase
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            din         <= DQS_IDLE_D;
            tin         <= DQS_IDLE_T;
            dci_disable <= 1'b1;
            busy        <= 1'b0;
            wr_data_en  <= 1'b0;
            last        <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            din         <= w_din;
            tin         <= w_tin;
            dci_disable <= w_dci_disable;
            busy        <= w_busy;
            wr_data_en  <= w_wr_data_en;
            last        <= w_last;
        end
    end

endmodule
`default_nettype wire

// File: doc/dqs_wr_pattern.md
# dqs_wr_pattern

Per-byte-lane DQS sequencer that produces the 4-bit parallel DQS data/tristate slices (`din`/`tin`) and the `dci_disable` control for the DQS I/O cell, one slice per `clk_div` cycle. For every write it generates the DDR3 write preamble, toggling burst and postamble. For every read it opens a DCI termination window. It sits between the command sequencer and the DQS serializer/IOB stage of each byte lane.

## Interface
Parameters:
- `LEN_WIDTH`, 6: width of burst-count inputs. A value of n requests n+1 BL8 bursts.
- `DCI_GUARD`, 1: extra `clk_div` cycles of termination before and after a read window, range 0..3.

Ports:
- `clk_div` in 1: lane clock; the serializer's divided clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_start` in 1: single-cycle write request.
- `wr_bursts` in LEN_WIDTH: number of write bursts minus 1; sampled with `wr_start`.
- `rd_start` in 1: single-cycle read request.
- `rd_bursts` in LEN_WIDTH: number of read bursts minus 1; sampled with `rd_start`.
- `busy` out 1: block not in IDLE.
- `wr_data_en` out 1: high on every BURST slice; DQ lanes align to it.
- `last` out 1: high on the final BURST slice.
- `din` out 4: DQS data slice. Bit 0 is earliest in time.
- `tin` out 4: DQS tristate slice. 1 = high-Z; bit 0 is earliest.
- `dci_disable` out 1: 1 = termination off.

## Operation
- States: IDLE, PRE, BURST, POST, RD.
- Slices per state (`din`/`tin`):
  - IDLE: 0000 / 1111
  - PRE: 0000 / 0011 (high-Z first tCK-half pair, driven low for the second)
  - BURST: 0101 / 0000 (high first)
  - POST: 0000 / 1110 (0.5 tCK low, then release)
  - RD: IDLE slice
- IDLE + `wr_start` → PRE. Load cnt = 2·(`wr_bursts`+1)−1. Each BL8 occupies 2 slices.
- PRE → BURST unconditionally after 1 cycle.
- BURST:
  - Decrement cnt each cycle.
  - At cnt==0, `last`=1, then → POST.
- POST → IDLE after 1 cycle.
- IDLE + `rd_start` (with `wr_start` low) → RD.
  - Load cnt = 2·(`rd_bursts`+1) + 2·DCI_GUARD − 1.
  - `dci_disable`=0 for every RD cycle.
  - RD → IDLE at cnt==0.
- `dci_disable`=1 in every state except RD.
- `wr_start` and `rd_start` together in IDLE: the write is taken and the read is dropped.
- Requests arriving while `busy`=1 are ignored, except as described under Configuration.
- Counter width is LEN_WIDTH+2. No wrap is possible at maximum `wr_bursts`/`rd_bursts` with DCI_GUARD≤3.

## Timing
- All outputs are registered. A request sampled on edge k produces its first slice (PRE or RD) on cycle k+1.
- Write of N+1 bursts:
  - PRE at k+1
  - BURST at k+2 .. k+2N+3
  - POST at k+2N+4
  - IDLE at k+2N+5
  - `busy` is high k+1 .. k+2N+4. A new request is accepted on edge k+2N+5.
- Read of N+1 bursts: `dci_disable` is low for exactly 2(N+1)+2·DCI_GUARD cycles, starting at k+1.
- Reset values: `din`=0000, `tin`=1111, `dci_disable`=1, `busy`=0, `wr_data_en`=0, `last`=0, state IDLE, cnt 0.
- Reset asserted mid-burst forces the reset values immediately (asynchronously). No postamble is emitted.

## Configuration
- `DQS_WR_SEAMLESS_EN` defined:
  - A `wr_start` sampled while `last`=1 reloads cnt from `wr_bursts` and stays in BURST.
  - No POST/PRE is inserted, so the DQS toggling is continuous.
  - `rd_start` during `last` is still ignored.
- Not defined: `wr_start` while `busy` is always ignored. Every write carries its own PRE and POST.

## Structure
- Package `dqs_pattern_pkg`:
  - state enum
  - slice constants DQS_IDLE_D/T, DQS_PRE_D/T, DQS_BURST_D/T, DQS_POST_D/T
- Single module: one FSM, one down-counter and registered output decode. No sub-module is warranted.

## Test plan
- Reset, then idle 10 cycles → `din`=0000, `tin`=1111, `dci_disable`=1, `busy`=0 throughout.
- `wr_start`, `wr_bursts`=0 at edge 5:
  - PRE (0000/0011) at 6
  - BURST 0101/0000 at 7–8, with `last` at 8
  - POST 0000/1110 at 9
  - IDLE at 10
- `rd_start`, `rd_bursts`=1, DCI_GUARD=1 → `dci_disable` low for exactly 6 cycles. `tin` stays 1111.
- `wr_start` and `rd_start` in the same cycle → write sequence only; `dci_disable` never drops.
- With the macro, `wr_start` on the `last` cycle of a 1-burst write, `wr_bursts`=1 → 6 contiguous BURST slices, a single PRE and a single POST. Without the macro, the second request is ignored.
- `rst_n` pulled low during the 3rd BURST slice → outputs return to reset values in the same cycle. After release, the first `wr_start` produces a normal PRE.
